// File: rtl/mem_access_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl_pkg
//
// Shared definitions for the memory-stage access sequencer:
//   - XLEN (data/address width, fixed at 32 for four byte lanes)
//   - FSM state encoding
//   - access size codes and byte-lane mask constants
//   - helpers for alignment, lane enables and store-data replication
//
// The optional WAIT timeout is enabled by defining MEM_TIMEOUT_EN at build
// time; it is undefined (feature off) by default.
// -----------------------------------------------------------------------------
package mem_access_ctrl_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Access size codes; code 3 is reserved and behaves as a word.
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam logic [3:0] LANES_BYTE = 4'b0001;
    localparam logic [3:0] LANES_HALF = 4'b0011;
    localparam logic [3:0] LANES_WORD = 4'b1111;

    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_BYTE: return 1'b1;
            SZ_HALF: return ~off[0];
            default: return (off == 2'b00);
        endcase
    endfunction

    function automatic logic [3:0] lane_enables(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_BYTE: return LANES_BYTE << off;
            SZ_HALF: return LANES_HALF << off;
            default: return LANES_WORD;
        endcase
    endfunction

    // Store data is right-justified; copy it into every lane so the memory
    // picks the right bytes using only the lane enables.
    function automatic logic [XLEN-1:0] replicate_wdata(input logic [1:0] size,
                                                        input logic [XLEN-1:0] wdata);
        case (size)
            SZ_BYTE: return {4{wdata[7:0]}};
            SZ_HALF: return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_ctrl_load_align.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl_load_align
//
// Combinational load aligner: shifts the returned word right by 8*offset,
// keeps the bytes belonging to the access size and sign- or zero-extends.
//
// Ports:
//   word_i      XLEN  raw word returned by data memory
//   offset_i    2     byte offset of the access within the word
//   size_i      2     access size code (byte/half/word, 3 treated as word)
//   unsigned_i  1     zero-extend instead of sign-extend
//   result_o    XLEN  aligned, extended load value
// -----------------------------------------------------------------------------
module mem_access_ctrl_load_align
    import mem_access_ctrl_pkg::*;
(
    input  logic [XLEN-1:0] word_i,
    input  logic [1:0]      offset_i,
    input  logic [1:0]      size_i,
    input  logic            unsigned_i,
    output logic [XLEN-1:0] result_o
);

    logic [XLEN-1:0] shifted;
    logic            byte_sign;
    logic            half_sign;

    always_comb begin
        shifted   = word_i >> {offset_i, 3'b000};
        byte_sign = shifted[7] & ~unsigned_i;
        half_sign = shifted[15] & ~unsigned_i;
        case (size_i)
            SZ_BYTE: result_o = {{(XLEN-8){byte_sign}}, shifted[7:0]};
            SZ_HALF: result_o = {{(XLEN-16){half_sign}}, shifted[15:0]};
            default: result_o = shifted;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
//
// Memory-stage sequencer. Issues loads/stores on the data-memory req/ack port,
// stalls the upstream pipeline and bubbles the M/D register while an access
// is outstanding, and returns aligned/extended load data in the DONE cycle.
//
// Build option: define MEM_TIMEOUT_EN to enable the WAIT timeout (counter,
// fault_o pulse). Without it fault_o is tied low and WAIT lasts until ack.
//
// Parameters:
//   TIMEOUT_CYCLES  WAIT cycles before a timeout fault (1..255)
//
// Ports:
//   clk_i, rst_n_i              clock, asynchronous active-low reset
//   ED_mem_rd_i / ED_mem_wr_i   load / store in the M stage
//   ED_size_i, ED_unsigned_i    access size, zero-extend load
//   ED_valE_i, ED_wdata_i       byte address, right-justified store data
//   dmem_req_o, dmem_we_o       memory request, write strobe
//   dmem_addr_o, dmem_be_o      word address, byte-lane enables
//   dmem_wdata_o                lane-replicated store data
//   dmem_ack_i, dmem_rdata_i    memory acknowledge, read word
//   M_valM_o                    aligned load data (DONE cycle only)
//   M_stall_o, M_bubble_o       pipeline hold / M/D bubble
//   misalign_o, fault_o         misaligned-access / timeout pulses
// -----------------------------------------------------------------------------
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            ED_mem_rd_i,
    input  logic            ED_mem_wr_i,
    input  logic [1:0]      ED_size_i,
    input  logic            ED_unsigned_i,
    input  logic [XLEN-1:0] ED_valE_i,
    input  logic [XLEN-1:0] ED_wdata_i,
    output logic            dmem_req_o,
    output logic            dmem_we_o,
    output logic [XLEN-1:0] dmem_addr_o,
    output logic [3:0]      dmem_be_o,
    output logic [XLEN-1:0] dmem_wdata_o,
    input  logic            dmem_ack_i,
    input  logic [XLEN-1:0] dmem_rdata_i,
    output logic [XLEN-1:0] M_valM_o,
    output logic            M_stall_o,
    output logic            M_bubble_o,
    output logic            misalign_o,
    output logic            fault_o
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("mem_access_ctrl: TIMEOUT_CYCLES must be in 1..255");
    end

    state_e          state_q, state_d;
    logic            tout_q, tout_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic [3:0]      be_q, be_d;
    logic [1:0]      off_q, off_d;
    logic [1:0]      size_q, size_d;
    logic            we_q, we_d;
    logic            uns_q, uns_d;
    logic            load_q, load_d;

    logic            mem_op;
    logic            aligned;
    logic            accept;
    logic            timeout_hit;
    logic [XLEN-1:0] load_val;

`ifdef MEM_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] cnt_q, cnt_d;

    // cnt_q counts completed WAIT cycles, so matching TO_LAST marks the
    // TIMEOUT_CYCLES-th WAIT cycle.
    assign timeout_hit = (cnt_q == TO_LAST);
    assign fault_o     = (state_q == ST_DONE) & tout_q;
`else
    assign timeout_hit = 1'b0;
    assign fault_o     = 1'b0;
`endif

    mem_access_ctrl_load_align u_load_align (
        .word_i     (rdata_q),
        .offset_i   (off_q),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .result_o   (load_val)
    );

    // Next-state and latch logic
    always_comb begin
        mem_op  = ED_mem_rd_i | ED_mem_wr_i;
        aligned = is_aligned(ED_size_i, ED_valE_i[1:0]);
        // Gating with rst_n_i keeps the request low while reset is held even
        // though the IDLE request path is combinational from the inputs.
        accept  = rst_n_i & mem_op & aligned & (state_q == ST_IDLE);

        state_d = state_q;
        tout_d  = tout_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        be_d    = be_q;
        off_d   = off_q;
        size_d  = size_q;
        we_d    = we_q;
        uns_d   = uns_q;
        load_d  = load_q;
`ifdef MEM_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    addr_d  = {ED_valE_i[XLEN-1:2], 2'b00};
                    wdata_d = replicate_wdata(ED_size_i, ED_wdata_i);
                    be_d    = lane_enables(ED_size_i, ED_valE_i[1:0]);
                    off_d   = ED_valE_i[1:0];
                    size_d  = ED_size_i;
                    we_d    = ED_mem_wr_i;
                    uns_d   = ED_unsigned_i;
                    load_d  = ED_mem_rd_i;
                    tout_d  = 1'b0;
`ifdef MEM_TIMEOUT_EN
                    cnt_d   = 8'd0;
`endif
                    if (dmem_ack_i) begin
                        state_d = ST_DONE;
                        if (ED_mem_rd_i) begin
                            rdata_d = dmem_rdata_i;
                        end
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
`ifdef MEM_TIMEOUT_EN
                cnt_d = cnt_q + 8'd1;
`endif
                if (dmem_ack_i) begin
                    state_d = ST_DONE;
                    if (load_q) begin
                        rdata_d = dmem_rdata_i;
                    end
                end else if (timeout_hit) begin
                    state_d = ST_DONE;
                    tout_d  = 1'b1;
                end
            end
            ST_DONE: begin
                // Inputs still describe the instruction just completed.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode
    always_comb begin
        dmem_req_o   = 1'b0;
        dmem_we_o    = 1'b0;
        dmem_addr_o  = '0;
        dmem_be_o    = 4'b0000;
        dmem_wdata_o = '0;
        M_valM_o     = '0;
        M_stall_o    = 1'b0;
        M_bubble_o   = 1'b0;
        misalign_o   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    dmem_req_o   = 1'b1;
                    dmem_we_o    = we_d;
                    dmem_addr_o  = addr_d;
                    dmem_be_o    = be_d;
                    dmem_wdata_o = wdata_d;
                    M_stall_o    = 1'b1;
                    M_bubble_o   = 1'b1;
                end
                misalign_o = rst_n_i & mem_op & ~aligned;
            end
            ST_WAIT: begin
                dmem_req_o   = 1'b1;
                dmem_we_o    = we_q;
                dmem_addr_o  = addr_q;
                dmem_be_o    = be_q;
                dmem_wdata_o = wdata_q;
                M_stall_o    = 1'b1;
                M_bubble_o   = 1'b1;
            end
            ST_DONE: begin
                if (load_q && !tout_q) begin
                    M_valM_o = load_val;
                end
            end
            default: ;
        endcase
    end

    // Control state: FSM, timeout flag and counter
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            tout_q  <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            cnt_q   <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            tout_q  <= tout_d;
`ifdef MEM_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    // Access context; only observed outside IDLE, so no reset is needed
    always_ff @(posedge clk_i) begin
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        rdata_q <= rdata_d;
        be_q    <= be_d;
        off_q   <= off_d;
        size_q  <= size_d;
        we_q    <= we_d;
        uns_q   <= uns_d;
        load_q  <= load_d;
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_access_ctrl
//
// Self-checking bench for mem_access_ctrl. Directed cases from the access
// scenarios followed by randomized loads/stores with random memory latency,
// compared against a byte-lane reference model.
// -----------------------------------------------------------------------------
module tb_mem_access_ctrl;

    localparam int TO = 4;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        ED_mem_rd_i, ED_mem_wr_i;
    logic [1:0]  ED_size_i;
    logic        ED_unsigned_i;
    logic [31:0] ED_valE_i, ED_wdata_i;
    logic        dmem_req_o, dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_ack_i;
    logic [31:0] dmem_rdata_i;
    logic [31:0] M_valM_o;
    logic        M_stall_o, M_bubble_o, misalign_o, fault_o;

    int unsigned assert_cnt = 0;
    int unsigned fail_cnt   = 0;

    always #5 clk_i = ~clk_i;

    mem_access_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .ED_mem_rd_i   (ED_mem_rd_i),
        .ED_mem_wr_i   (ED_mem_wr_i),
        .ED_size_i     (ED_size_i),
        .ED_unsigned_i (ED_unsigned_i),
        .ED_valE_i     (ED_valE_i),
        .ED_wdata_i    (ED_wdata_i),
        .dmem_req_o    (dmem_req_o),
        .dmem_we_o     (dmem_we_o),
        .dmem_addr_o   (dmem_addr_o),
        .dmem_be_o     (dmem_be_o),
        .dmem_wdata_o  (dmem_wdata_o),
        .dmem_ack_i    (dmem_ack_i),
        .dmem_rdata_i  (dmem_rdata_i),
        .M_valM_o      (M_valM_o),
        .M_stall_o     (M_stall_o),
        .M_bubble_o    (M_bubble_o),
        .misalign_o    (misalign_o),
        .fault_o       (fault_o)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        assert_cnt++;
        if (act !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    // ---------------- reference model (byte-lane view) ----------------
    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic bit ref_aligned(input logic [1:0] sz, input logic [31:0] addr);
        return (addr % nbytes(sz)) == 0;
    endfunction

    function automatic logic [3:0] ref_be(input logic [1:0] sz, input int off);
        logic [3:0] be = 4'b0000;
        for (int i = 0; i < 4; i++)
            if (i >= off && i < off + nbytes(sz)) be[i] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [1:0] sz, input logic [31:0] wd);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % nbytes(sz)) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] sz, input bit uns,
                                             input int off, input logic [31:0] rd);
        logic [31:0] v = 32'h0;
        int n = nbytes(sz);
        for (int i = 0; i < n; i++) v[8*i +: 8] = rd[8*(off+i) +: 8];
        if (!uns && v[8*n-1])
            for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
        return v;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic check_quiet(input string tag);
        chk({tag, "_ctl"}, {25'b0, dmem_req_o, dmem_we_o, M_stall_o, M_bubble_o,
                            misalign_o, fault_o, |dmem_be_o}, 32'h0);
        chk({tag, "_addr"},  dmem_addr_o,  32'h0);
        chk({tag, "_wdata"}, dmem_wdata_o, 32'h0);
        chk({tag, "_valM"},  M_valM_o,     32'h0);
    endtask

    task automatic idle_cycle();
        @(negedge clk_i);
        ED_mem_rd_i = 1'b0; ED_mem_wr_i = 1'b0;
        dmem_ack_i = 1'b0; dmem_rdata_i = $urandom;
        #1 check_quiet("idle");
    endtask

    task automatic perturb_inputs();
        ED_valE_i     = $urandom;
        ED_wdata_i    = $urandom;
        ED_size_i     = 2'($urandom_range(0, 3));
        ED_unsigned_i = 1'($urandom_range(0, 1));
    endtask

    // One full access: issue cycle, lat WAIT cycles (ack on the last), DONE.
    task automatic do_txn(input bit wr, input logic [1:0] sz, input bit uns,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] rd, input int lat);
        bit al = ref_aligned(sz, addr);
        int off = int'(addr % 4);
        @(negedge clk_i);
        ED_mem_rd_i = !wr; ED_mem_wr_i = wr; ED_size_i = sz; ED_unsigned_i = uns;
        ED_valE_i = addr; ED_wdata_i = wd;
        if (!al) begin
            dmem_ack_i = 1'b0;
            #1;
            chk("mis_pulse", {31'b0, misalign_o}, 32'h1);
            chk("mis_noreq", {29'b0, dmem_req_o, M_stall_o, M_bubble_o}, 32'h0);
            chk("mis_valM", M_valM_o, 32'h0);
            idle_cycle();
            return;
        end
        for (int k = 0; k <= lat; k++) begin
            if (k > 0) begin
                @(negedge clk_i);
                perturb_inputs();
            end
            dmem_ack_i   = (k == lat);
            dmem_rdata_i = (k == lat) ? rd : $urandom;
            #1;
            chk("req_stall", {29'b0, dmem_req_o, M_stall_o, M_bubble_o}, 32'h7);
            chk("we",    {31'b0, dmem_we_o}, {31'b0, wr});
            chk("addr",  dmem_addr_o, addr & 32'hFFFF_FFFC);
            chk("be",    {28'b0, dmem_be_o}, {28'b0, ref_be(sz, off)});
            chk("wdata", dmem_wdata_o, ref_wdata(sz, wd));
            chk("no_mis_flt", {30'b0, misalign_o, fault_o}, 32'h0);
        end
        @(negedge clk_i);
        perturb_inputs();
        dmem_ack_i = 1'b0; dmem_rdata_i = $urandom;
        #1;
        chk("done_ctl", {27'b0, dmem_req_o, M_stall_o, M_bubble_o, misalign_o, fault_o}, 32'h0);
        chk("done_valM", M_valM_o, wr ? 32'h0 : ref_load(sz, uns, off, rd));
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int held;
        rst_n_i = 1'b0;
        ED_mem_rd_i = 1'b0; ED_mem_wr_i = 1'b0; ED_size_i = 2'd2; ED_unsigned_i = 1'b0;
        ED_valE_i = 32'h0; ED_wdata_i = 32'h0; dmem_ack_i = 1'b0; dmem_rdata_i = 32'h0;
        repeat (2) @(negedge clk_i);
        #1 check_quiet("reset");
        // A request presented while reset is held must not reach memory.
        ED_mem_rd_i = 1'b1; ED_valE_i = 32'h40;
        #1 check_quiet("reset_op");
        @(negedge clk_i);
        ED_mem_rd_i = 1'b0;
        rst_n_i = 1'b1;
        idle_cycle();

        // Directed scenarios
        do_txn(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 0);
        do_txn(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 32'h80FFFFFF, 3);
        do_txn(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 32'h80FFFFFF, 3);
        do_txn(1'b1, 2'd1, 1'b0, 32'h22, 32'h1234ABCD, 32'h0, 2);
        do_txn(1'b0, 2'd2, 1'b0, 32'h05, 32'h0, 32'h0, 0);
        do_txn(1'b0, 2'd1, 1'b0, 32'h102, 32'h0, 32'h8001_7FFF, 1);
        do_txn(1'b0, 2'd3, 1'b0, 32'h104, 32'h0, 32'h1357_9BDF, 0);
        idle_cycle();

        // Randomized back-to-back traffic with occasional idle gaps
        for (int t = 0; t < 60; t++) begin
            do_txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
                   $urandom_range(0, 4));
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end
        idle_cycle();

        // Reset asserted mid-WAIT
        @(negedge clk_i);
        ED_mem_rd_i = 1'b1; ED_size_i = 2'd2; ED_valE_i = 32'h40; dmem_ack_i = 1'b0;
        #1 chk("rst_pre_req", {31'b0, dmem_req_o}, 32'h1);
        @(negedge clk_i);
        #1 chk("rst_wait_req", {31'b0, dmem_req_o}, 32'h1);
        #1 rst_n_i = 1'b0;
        #1 check_quiet("rst_mid_wait");
        @(negedge clk_i);
        ED_mem_rd_i = 1'b0;
        rst_n_i = 1'b1;
        idle_cycle();
        do_txn(1'b0, 2'd2, 1'b0, 32'h80, 32'h0, 32'hCAFEF00D, 1);
        idle_cycle();

        // No acknowledge at all
        @(negedge clk_i);
        ED_mem_rd_i = 1'b1; ED_size_i = 2'd2; ED_valE_i = 32'h44; dmem_ack_i = 1'b0;
`ifdef MEM_TIMEOUT_EN
        for (int k = 0; k <= TO; k++) begin
            if (k > 0) @(negedge clk_i);
            #1 chk("to_req", {30'b0, dmem_req_o, fault_o}, 32'h2);
        end
        @(negedge clk_i);
        #1;
        chk("to_fault", {29'b0, dmem_req_o, M_stall_o, fault_o}, 32'h1);
        chk("to_valM", M_valM_o, 32'h0);
        idle_cycle();
`else
        held = 0;
        for (int k = 0; k < 301; k++) begin
            if (k > 0) @(negedge clk_i);
            #1 if (dmem_req_o && M_stall_o && M_bubble_o && !fault_o) held++;
        end
        chk("no_timeout_held", held, 301);
        rst_n_i = 1'b0;
        @(negedge clk_i);
        ED_mem_rd_i = 1'b0;
        rst_n_i = 1'b1;
        idle_cycle();
`endif
        do_txn(1'b1, 2'd0, 1'b0, 32'h4B, 32'h0000_00A5, 32'h0, 0);
        idle_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
        $finish;
    end

endmodule
